// File: rtl/line_fill_buf_pkg.sv
// Shared constants and state encoding for the 64-bit line fill buffer.
package line_fill_buf_pkg;

  localparam int WORD_W = 16;
  localparam int WORDS  = 4;
  localparam int LINE_W = 64;
  localparam int CNT_W  = 3;

  localparam logic [15:0] LINE_ALIGN_MASK = 16'hFFF8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/line_fill_buf_fill_ctr.sv
// Small up/down counter with synchronous clear; used for the request,
// response and outstanding-request counts of the line fill buffer.
module fill_ctr
  import line_fill_buf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      cnt_d = cnt_q + 3'd1;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/line_fill_buf.sv
// Issues four word reads for a missed line, gathers the in-order responses
// and presents the assembled line with a one-cycle write enable.
module line_fill_buf
  import line_fill_buf_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [15:0]         base_addr,
  output logic                mem_rd,
  output logic [15:0]         mem_addr,
  input  logic                mem_stall,
  input  logic                mem_rvalid,
  input  logic [WORD_W-1:0]   mem_rdata,
  output logic [LINE_W-1:0]   line,
  output logic                line_we,
  output logic                busy,
  output logic                done
);

  state_t            state_q, state_d;
  logic [15:0]       aligned_q, aligned_d;
  logic [WORD_W-1:0] slot_q [WORDS];
  logic [WORD_W-1:0] slot_d [WORDS];

  logic [CNT_W-1:0]  req_cnt, resp_cnt, outstanding;
  logic              cnt_clr, req_inc, resp_inc, out_dec;
  logic              rsp_ok;

  // A response with nothing outstanding is a protocol error and is dropped.
  assign rsp_ok = mem_rvalid && (outstanding != 3'd0);

  always_comb begin
    state_d   = state_q;
    aligned_d = aligned_q;
    cnt_clr   = 1'b0;
    req_inc   = 1'b0;
    resp_inc  = 1'b0;
    out_dec   = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = 16'h0000;
    line_we   = 1'b0;
    done      = 1'b0;
    busy      = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          aligned_d = base_addr & LINE_ALIGN_MASK;
          cnt_clr   = 1'b1;
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        if (abort) begin
          // Abort wins: no request this cycle, a coincident response is drained.
          out_dec = rsp_ok;
          if (outstanding == {2'b00, rsp_ok}) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          mem_rd   = (req_cnt < 3'd4);
          mem_addr = mem_rd ? (aligned_q + {12'h000, req_cnt, 1'b0}) : 16'h0000;
          req_inc  = mem_rd && !mem_stall;
          resp_inc = rsp_ok;
          out_dec  = rsp_ok;
          if (rsp_ok && (resp_cnt == 3'd3)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DRAIN: begin
        out_dec = rsp_ok;
        if (rsp_ok && (outstanding == 3'd1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        line_we = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < WORDS; k++) begin
      slot_d[k] = slot_q[k];
      if (resp_inc && (resp_cnt == 3'(k))) begin
        slot_d[k] = mem_rdata;
      end
    end
  end

  always_comb begin
    line = '0;
    for (int k = 0; k < WORDS; k++) begin
      line[k*WORD_W +: WORD_W] = slot_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      aligned_q <= 16'h0000;
      for (int k = 0; k < WORDS; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      aligned_q <= aligned_d;
      for (int k = 0; k < WORDS; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  fill_ctr u_req_ctr (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (req_inc),
    .dec (1'b0),
    .cnt (req_cnt)
  );

  fill_ctr u_resp_ctr (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (resp_inc),
    .dec (1'b0),
    .cnt (resp_cnt)
  );

  fill_ctr u_out_ctr (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (req_inc),
    .dec (out_dec),
    .cnt (outstanding)
  );

endmodule

// File: tb/tb_line_fill_buf.sv
// Directed bench for line_fill_buf: a table-driven zero-wait fill plus
// hand-written stall, abort, reset and stray-input sequences.
module tb_line_fill_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] base_addr;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_stall;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic [63:0] line;
  logic        line_we;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  line_fill_buf dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_stall  (mem_stall),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .line       (line),
    .line_we    (line_we),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic        start;
    logic [15:0] base;
    logic        rvalid;
    logic [15:0] rdata;
    logic        exp_rd;
    logic [15:0] exp_addr;
    logic        exp_we;
    logic        exp_busy;
    logic [63:0] exp_line;
  } vec_t;

  vec_t vt [8];

  logic        st_stall [8];
  logic        st_rv    [8];
  logic [15:0] st_data  [8];
  logic [15:0] st_addr  [8];
  logic        st_rd    [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic [15:0] b, input logic st,
                        input logic rv, input logic [15:0] rd, input logic ab);
    start      = s;
    base_addr  = b;
    mem_stall  = st;
    mem_rvalid = rv;
    mem_rdata  = rd;
    abort      = ab;
  endtask

  // Zero-wait fill with optional start held through the fill and abort in DONE.
  task automatic run_fill(input logic [15:0] base, input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3,
                          input logic hold_start, input logic abort_done);
    logic [15:0] al;
    logic [15:0] d [4];
    logic [63:0] exp_line;
    al = base & 16'hFFF8;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    exp_line = {d3, d2, d1, d0};
    set_in(1'b1, base, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    chk("rf_idle_busy", 64'(busy), 64'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      set_in(hold_start, 16'hFFFF, 1'b0, (k > 0), (k > 0) ? d[k-1] : 16'h0, 1'b0);
      @(negedge clk);
      chk("rf_rd", 64'(mem_rd), (k < 4) ? 64'd1 : 64'd0);
      chk("rf_addr", 64'(mem_addr), (k < 4) ? 64'(al + 16'(2*k)) : 64'd0);
      chk("rf_we_early", 64'(line_we), 64'd0);
      tick();
    end
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, abort_done);
    @(negedge clk);
    chk("rf_we", 64'(line_we), 64'd1);
    chk("rf_done", 64'(done), 64'd1);
    chk("rf_line", line, exp_line);
    tick();
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    chk("rf_we_after", 64'(line_we), 64'd0);
    chk("rf_busy_after", 64'(busy), 64'd0);
    chk("rf_line_hold", line, exp_line);
    tick();
  endtask

  initial begin
    int accepted;
    logic any_we;

    vt[0] = '{1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 64'h0};
    vt[1] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h1230, 1'b0, 1'b1, 64'h0};
    vt[2] = '{1'b0, 16'h0000, 1'b1, 16'hAAAA, 1'b1, 16'h1232, 1'b0, 1'b1, 64'h0};
    vt[3] = '{1'b0, 16'h0000, 1'b1, 16'hBBBB, 1'b1, 16'h1234, 1'b0, 1'b1, 64'h0000_0000_0000_AAAA};
    vt[4] = '{1'b0, 16'h0000, 1'b1, 16'hCCCC, 1'b1, 16'h1236, 1'b0, 1'b1, 64'h0000_0000_BBBB_AAAA};
    vt[5] = '{1'b0, 16'h0000, 1'b1, 16'hDDDD, 1'b0, 16'h0000, 1'b0, 1'b1, 64'h0000_CCCC_BBBB_AAAA};
    vt[6] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 64'hDDDD_CCCC_BBBB_AAAA};
    vt[7] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 64'hDDDD_CCCC_BBBB_AAAA};

    st_stall = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    st_rv    = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    st_data  = '{16'h0, 16'h1111, 16'h0, 16'h0, 16'h0, 16'h2222, 16'h3333, 16'h4444};
    st_addr  = '{16'h1230, 16'h1232, 16'h1232, 16'h1232, 16'h1232, 16'h1234, 16'h1236, 16'h0000};
    st_rd    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset
    rst = 1'b1;
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    tick();
    @(negedge clk);
    chk("rst_rd", 64'(mem_rd), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_line", line, 64'd0);
    chk("rst_we", 64'(line_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    tick();
    rst = 1'b0;

    // Zero-wait fill from the vector table
    for (int i = 0; i < 8; i++) begin
      set_in(vt[i].start, vt[i].base, 1'b0, vt[i].rvalid, vt[i].rdata, 1'b0);
      @(negedge clk);
      chk($sformatf("zw%0d_rd", i), 64'(mem_rd), 64'(vt[i].exp_rd));
      chk($sformatf("zw%0d_addr", i), 64'(mem_addr), 64'(vt[i].exp_addr));
      chk($sformatf("zw%0d_we", i), 64'(line_we), 64'(vt[i].exp_we));
      chk($sformatf("zw%0d_done", i), 64'(done), 64'(vt[i].exp_we));
      chk($sformatf("zw%0d_busy", i), 64'(busy), 64'(vt[i].exp_busy));
      chk($sformatf("zw%0d_line", i), line, vt[i].exp_line);
      tick();
    end

    // Stray response in IDLE
    set_in(1'b0, 16'h0, 1'b0, 1'b1, 16'h9999, 1'b0);
    tick();
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    chk("stray_line", line, 64'hDDDD_CCCC_BBBB_AAAA);
    chk("stray_busy", 64'(busy), 64'd0);
    tick();

    // Stalled second request
    set_in(1'b1, 16'h1235, 1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    accepted = 0;
    for (int c = 0; c < 8; c++) begin
      set_in(1'b0, 16'h0, st_stall[c], st_rv[c], st_data[c], 1'b0);
      @(negedge clk);
      chk($sformatf("stall%0d_rd", c), 64'(mem_rd), 64'(st_rd[c]));
      chk($sformatf("stall%0d_addr", c), 64'(mem_addr), 64'(st_addr[c]));
      if (mem_rd && !mem_stall) accepted++;
      tick();
    end
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    chk("stall_accepted", 64'(accepted), 64'd4);
    chk("stall_we", 64'(line_we), 64'd1);
    chk("stall_line", line, 64'h4444_3333_2222_1111);
    tick();

    // Abort with two requests outstanding
    any_we = 1'b0;
    set_in(1'b1, 16'h2007, 1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    chk("ab_addr0", 64'(mem_addr), 64'h2000);
    tick();
    set_in(1'b0, 16'h0, 1'b0, 1'b1, 16'h00E0, 1'b0);
    @(negedge clk);
    chk("ab_addr1", 64'(mem_addr), 64'h2002);
    tick();
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    chk("ab_addr2", 64'(mem_addr), 64'h2004);
    tick();
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    @(negedge clk);
    chk("ab_rd_cut", 64'(mem_rd), 64'd0);
    any_we |= line_we;
    tick();
    set_in(1'b0, 16'h0, 1'b0, 1'b1, 16'h00E1, 1'b0);
    @(negedge clk);
    chk("ab_drain1_busy", 64'(busy), 64'd1);
    chk("ab_drain1_rd", 64'(mem_rd), 64'd0);
    any_we |= line_we;
    tick();
    set_in(1'b0, 16'h0, 1'b0, 1'b1, 16'h00E2, 1'b0);
    @(negedge clk);
    chk("ab_drain2_busy", 64'(busy), 64'd1);
    any_we |= line_we;
    tick();
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    chk("ab_idle_busy", 64'(busy), 64'd0);
    any_we |= line_we;
    chk("ab_no_we", 64'(any_we), 64'd0);
    tick();

    // Reset in the middle of a fill
    set_in(1'b1, 16'h4000, 1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    chk("mr_addr0", 64'(mem_addr), 64'h4000);
    tick();
    @(negedge clk);
    chk("mr_addr1", 64'(mem_addr), 64'h4002);
    tick();
    rst = 1'b1;
    set_in(1'b0, 16'h0, 1'b0, 1'b1, 16'h7777, 1'b0);
    tick();
    rst = 1'b0;
    set_in(1'b0, 16'h0, 1'b0, 1'b1, 16'h8888, 1'b0);
    @(negedge clk);
    chk("mr_rd", 64'(mem_rd), 64'd0);
    chk("mr_addr", 64'(mem_addr), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_we", 64'(line_we), 64'd0);
    chk("mr_line", line, 64'd0);
    tick();
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    chk("mr_line_after_stray", line, 64'd0);
    tick();

    // Fill after reset, with start held while busy and abort during DONE
    run_fill(16'h0008, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
